audio_ram_reader: RTL and testbench
===================================

# audio_ram_reader

Streaming read master for the second port (s2) of the 16384 x 8 dual-port audio sample RAM. The CPU/decoder writes PCM bytes through port s1 and publishes its write pointer. This block fetches little-endian 16-bit samples from port s2 behind that pointer and buffers them in a small FIFO. It presents the samples as a valid/ready stream to the DAC/I2S serializer.

## Interface
Parameters:
- ADDR_W, 14, byte address width of the audio RAM (depth 2^ADDR_W)
- FIFO_DEPTH, 4, sample FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  single clock, same clock as the RAM
- reset  in  1  synchronous, active-high
- enable  in  1  playback enable
- ptr_clr  in  1  forces rd_ptr to 0; honoured only in IDLE
- wr_ptr  in  ADDR_W  producer's next-write byte address
- rd_ptr  out  ADDR_W  next byte to fetch (consumer pointer)
- address2  out  ADDR_W  RAM port-2 address
- chipselect2  out  1  RAM port-2 select
- clken2  out  1  RAM port-2 clock enable (tied 1)
- write2  out  1  tied 0
- writedata2  out  8  tied 0
- readdata2  in  8  RAM port-2 data; valid the cycle after the address is presented
- sample_data  out  16  FIFO head sample
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  sink accepts the head sample
- underrun  out  1  sticky; set on starvation
- underrun_clr  in  1  clears underrun

## Operation
- avail = (wr_ptr − rd_ptr) mod 2^ADDR_W, computed in ADDR_W bits. wr_ptr == rd_ptr means empty. An odd avail is floored; a sample is never split across a fetch decision.
- The producer never fills to within 1 byte of rd_ptr; that is the producer's contract and is not checked here.
- FSM states:
  - IDLE: go to LO when enable && avail ≥ 2 && (fifo_count + 0 in-flight) < FIFO_DEPTH.
  - LO: address2 = rd_ptr, chipselect2 = 1. Go to HI.
  - HI: address2 = rd_ptr+1 (wraps), chipselect2 = 1. Capture readdata2 as the low byte. Go to CAP.
  - CAP: capture readdata2 as the high byte and push {hi, lo} into the FIFO. rd_ptr += 2 (wraps). Return to IDLE.
- enable deasserted mid-fetch: LO/HI/CAP run to completion and the sample is pushed. The FIFO is then flushed on the first IDLE cycle with enable low. rd_ptr is retained.
- ptr_clr in IDLE sets rd_ptr = 0 and flushes the FIFO. ptr_clr in other states is ignored.
- FIFO: push in CAP, pop on sample_valid && sample_ready. A simultaneous push and pop leaves the count unchanged. A push never occurs when full, guaranteed by the IDLE check.
- Underrun: set when enable && sample_ready && !sample_valid. underrun_clr clears it. If set and clear occur in the same cycle, set wins.
- chipselect2 is low in IDLE/CAP. address2 holds its last value when not selected.

## Timing
- Reset values: rd_ptr 0, address2 0, chipselect2 0, clken2 1, write2 0, writedata2 0, sample_data 0, sample_valid 0, underrun 0, FSM IDLE, FIFO empty.
- Fetch latency: if the IDLE condition is true in cycle k, LO runs in k+1, HI in k+2, CAP in k+3, and sample_valid is high in k+4 (show-ahead FIFO).
- Peak throughput is 1 sample per 4 cycles, far above audio rate.
- rd_ptr updates at the end of CAP. avail re-evaluates in the following IDLE cycle.
- wr_ptr is sampled combinationally each IDLE cycle and must be stable in the clk domain.

## Structure
- Package audio_pkg holds:
  - ADDR_W default, RAM_DEPTH, SAMPLE_W = 16
  - state enum {IDLE, LO, HI, CAP}
  - an avail() width rule constant
- Sub-module sample_fifo: synchronous show-ahead FIFO (width 16, depth FIFO_DEPTH) with push, pop, flush, count, full and empty.
- Top level contains the FSM, pointer logic, underrun flag and RAM port drive.

## Test plan
- Reset, then wr_ptr = 4, RAM holds 0x34,0x12,0x78,0x56 at addresses 0–3 -> samples 0x1234 then 0x5678; rd_ptr = 4; first sample_valid 4 cycles after enable.
- Wrap: rd_ptr = 16382 via prior fetches, wr_ptr = 2, bytes 0xCD@16382, 0xAB@16383, 0xEF@0, 0x01@1 -> samples 0xABCD, 0x01EF; rd_ptr = 2.
- Backpressure: sample_ready = 0 with 20 bytes available -> exactly FIFO_DEPTH (4) samples buffered, FSM parks in IDLE, rd_ptr = 8; releasing ready drains in order.
- Starvation: wr_ptr == rd_ptr, enable = 1, sample_ready = 1 -> underrun = 1 next cycle, no RAM access. underrun_clr together with a set -> stays 1.
- Odd avail: wr_ptr = rd_ptr + 3 -> one sample fetched; FSM waits until wr_ptr advances by 1 more.
- Disable during HI -> the sample completes and rd_ptr += 2, then the FIFO is flushed (sample_valid = 0). ptr_clr in IDLE -> rd_ptr = 0.

Source files
------------

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
//   Shared definitions for the audio sample RAM read path.
//   - ADDR_W_DEF       : default byte address width of the audio RAM
//   - RAM_DEPTH        : number of bytes in the audio RAM
//   - SAMPLE_W         : width of one PCM sample (little-endian byte pair)
//   - BYTES_PER_SAMPLE : bytes that must be available before a fetch starts
//   - AVAIL_W_EXTRA    : extra bits added to ADDR_W when computing avail;
//                        zero because avail is a modular difference that
//                        lives entirely in ADDR_W bits
//   - state_t          : fetch FSM states
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int ADDR_W_DEF       = 14;
  localparam int RAM_DEPTH        = 1 << ADDR_W_DEF;
  localparam int SAMPLE_W         = 16;
  localparam int BYTES_PER_SAMPLE = 2;
  localparam int AVAIL_W_EXTRA    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    CAP  = 2'd3
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Synchronous show-ahead FIFO. The head entry is visible on head_data
//   whenever the FIFO is non-empty (zero when empty), so a pop simply
//   advances to the next entry.
//
//   Ports:
//     clk        in   clock
//     reset      in   synchronous active-high reset
//     push       in   write push_data (ignored when full)
//     push_data  in   WIDTH-bit entry to store
//     pop        in   discard head entry (ignored when empty)
//     flush      in   discard all entries
//     head_data  out  current head entry
//     count      out  number of stored entries
//     full       out  count == DEPTH
//     empty      out  count == 0
// ---------------------------------------------------------------------------
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_L = DEPTH[IW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW:0]      count_q;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == DEPTH_L);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  // Show-ahead head; forced to zero when empty so the stream data output
  // never shows stale storage contents.
  assign head_data = empty ? '0 : mem[rd_idx];

  // Sample storage has no reset; only entries below count are ever visible.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Index and occupancy bookkeeping. DEPTH is a power of two, so the
  // indices wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (pop_en) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/audio_ram_reader.sv
// ---------------------------------------------------------------------------
// audio_ram_reader
//   Streaming read master for port 2 of the dual-port audio sample RAM.
//   Fetches little-endian 16-bit samples from behind the producer's write
//   pointer, buffers them in a show-ahead FIFO and presents them as a
//   valid/ready stream.
//
//   Ports:
//     clk           in   clock shared with the RAM
//     reset         in   synchronous active-high reset
//     enable        in   playback enable
//     ptr_clr       in   zero rd_ptr and flush the FIFO (IDLE only)
//     wr_ptr        in   producer's next-write byte address
//     rd_ptr        out  next byte to fetch
//     address2      out  RAM port-2 address
//     chipselect2   out  RAM port-2 select
//     clken2        out  RAM port-2 clock enable (constant 1)
//     write2        out  RAM port-2 write (constant 0)
//     writedata2    out  RAM port-2 write data (constant 0)
//     readdata2     in   RAM port-2 read data, one cycle after address
//     sample_data   out  FIFO head sample
//     sample_valid  out  FIFO non-empty
//     sample_ready  in   sink accepts the head sample
//     underrun      out  sticky starvation flag
//     underrun_clr  in   clears underrun (a same-cycle set wins)
// ---------------------------------------------------------------------------
module audio_ram_reader
  import audio_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ptr_clr,
  input  logic [ADDR_W-1:0]   wr_ptr,
  output logic [ADDR_W-1:0]   rd_ptr,
  output logic [ADDR_W-1:0]   address2,
  output logic                chipselect2,
  output logic                clken2,
  output logic                write2,
  output logic [7:0]          writedata2,
  input  logic [7:0]          readdata2,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] FIFO_DEPTH_L = FIFO_DEPTH[CW:0];
  localparam int AVAIL_W = ADDR_W + AVAIL_W_EXTRA;
  localparam logic [AVAIL_W-1:0] MIN_AVAIL = AVAIL_W'(BYTES_PER_SAMPLE);
  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(BYTES_PER_SAMPLE);

  state_t              state;
  state_t              state_next;
  logic [AVAIL_W-1:0]  avail;
  logic                start_fetch;
  logic                fifo_flush;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW:0]         fifo_count;
  logic [7:0]          lo_byte;
  logic [ADDR_W-1:0]   addr_hold;
  logic                underrun_set;

  // Read port never writes and is always clocked.
  assign clken2     = 1'b1;
  assign write2     = 1'b0;
  assign writedata2 = 8'h00;

  // Bytes the producer has published beyond our read pointer. The modular
  // subtraction handles wrap-around; an odd count is effectively floored by
  // the ">= 2" test, so a half sample is never fetched.
  assign avail = wr_ptr - rd_ptr;

  // Only one fetch is ever in flight and none is in flight while IDLE, so
  // the FIFO occupancy alone decides whether another sample fits.
  assign start_fetch = enable && (avail >= MIN_AVAIL) && (fifo_count < FIFO_DEPTH_L)
                       && !fifo_full && !ptr_clr;

  // Playback stop or pointer clear discards buffered samples, but only once
  // the FSM has returned to IDLE so an in-progress fetch still completes.
  assign fifo_flush = (state == IDLE) && (!enable || ptr_clr);
  assign fifo_push  = (state == CAP);
  assign fifo_pop   = sample_valid && sample_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and RAM port drive. The address is presented in LO and HI;
  // otherwise it holds its previous value with the select low.
  always_comb begin
    state_next  = state;
    chipselect2 = 1'b0;
    address2    = addr_hold;
    case (state)
      IDLE: begin
        if (start_fetch) begin
          state_next = LO;
        end
      end
      LO: begin
        chipselect2 = 1'b1;
        address2    = rd_ptr;
        state_next  = HI;
      end
      HI: begin
        chipselect2 = 1'b1;
        address2    = rd_ptr + ADDR_W'(1);
        state_next  = CAP;
      end
      CAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Remembers the last presented address so it can be held while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold <= '0;
    end else begin
      addr_hold <= address2;
    end
  end

  // Low byte arrives during HI (data for the LO address); the high byte is
  // taken straight off readdata2 in CAP when the sample is pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_byte <= 8'h00;
    end else if (state == HI) begin
      lo_byte <= readdata2;
    end
  end

  // Consumer pointer: cleared on request while idle, advanced by one sample
  // when the fetch completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if ((state == IDLE) && ptr_clr) begin
      rd_ptr <= '0;
    end else if (state == CAP) begin
      rd_ptr <= rd_ptr + PTR_STEP;
    end
  end

  // Sticky starvation flag; a new starvation event beats a clear request.
  assign underrun_set = enable && sample_ready && !sample_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({readdata2, lo_byte}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (sample_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sample_valid = !fifo_empty;

endmodule

// File: tb/tb_audio_ram_reader.sv
// ---------------------------------------------------------------------------
// tb_audio_ram_reader
//   Directed bench for audio_ram_reader with a behavioural one-cycle-latency
//   model of the audio RAM read port.
// ---------------------------------------------------------------------------
module tb_audio_ram_reader;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              ptr_clr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] address2;
  logic              chipselect2;
  logic              clken2;
  logic              write2;
  logic [7:0]        writedata2;
  logic [7:0]        readdata2;
  logic [15:0]       sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              underrun;
  logic              underrun_clr;

  logic [7:0] mem [1 << ADDR_W];

  int checks = 0;
  int errors = 0;

  audio_ram_reader #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ptr_clr      (ptr_clr),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .address2     (address2),
    .chipselect2  (chipselect2),
    .clken2       (clken2),
    .write2       (write2),
    .writedata2   (writedata2),
    .readdata2    (readdata2),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM port 2: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    readdata2 <= mem[address2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic [ADDR_W-1:0] wp);
    enable       = en;
    sample_ready = rdy;
    wr_ptr       = wp;
  endtask

  // Advance n clock edges, landing 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Check the head sample and pop it in a single handshake cycle.
  task automatic popOne(input string tag, input logic [15:0] expected);
    checkOutput({tag, "_valid"}, 32'(sample_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(sample_data), 32'(expected));
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_s [10];
    int idx;
    int cs_count;
    int cyc;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    readdata2    = 8'h00;
    reset        = 1'b1;
    ptr_clr      = 1'b0;
    underrun_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;
    tick(3);
    reset = 1'b0;
    tick(1);

    // ---- Reset values ----
    $display("[TB] reset values");
    checkOutput("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    checkOutput("rst_address2", 32'(address2), 32'd0);
    checkOutput("rst_cs2", 32'(chipselect2), 32'd0);
    checkOutput("rst_clken2", 32'(clken2), 32'd1);
    checkOutput("rst_write2", 32'(write2), 32'd0);
    checkOutput("rst_wdata2", 32'(writedata2), 32'd0);
    checkOutput("rst_sdata", 32'(sample_data), 32'd0);
    checkOutput("rst_svalid", 32'(sample_valid), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);

    // ---- Basic fetch and latency ----
    $display("[TB] basic fetch");
    applyStimulus(1'b1, 1'b0, 14'd4);
    tick(1);
    checkOutput("t1_lo_addr", 32'(address2), 32'd0);
    checkOutput("t1_lo_cs", 32'(chipselect2), 32'd1);
    tick(2);
    checkOutput("t1_valid_k3", 32'(sample_valid), 32'd0);
    tick(1);
    checkOutput("t1_valid_k4", 32'(sample_valid), 32'd1);
    checkOutput("t1_data_first", 32'(sample_data), 32'h1234);
    tick(4);
    checkOutput("t1_rd_ptr", 32'(rd_ptr), 32'd4);
    popOne("t1_s0", 16'h1234);
    popOne("t1_s1", 16'h5678);
    checkOutput("t1_empty", 32'(sample_valid), 32'd0);
    checkOutput("t1_no_underrun", 32'(underrun), 32'd0);

    // ---- Walk rd_ptr up to 16382, then wrap ----
    $display("[TB] wrap");
    applyStimulus(1'b1, 1'b1, 14'd16382);
    cyc = 0;
    while (rd_ptr != 14'd16382 && cyc < 40000) begin
      tick(1);
      cyc++;
    end
    checkOutput("t2_bulk_reach", 32'(rd_ptr), 32'd16382);
    tick(2);
    applyStimulus(1'b1, 1'b0, 14'd16382);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    checkOutput("t2_drained", 32'(sample_valid), 32'd0);
    checkOutput("t2_underrun_clr", 32'(underrun), 32'd0);
    mem[16382] = 8'hCD; mem[16383] = 8'hAB; mem[0] = 8'hEF; mem[1] = 8'h01;
    applyStimulus(1'b1, 1'b0, 14'd2);
    tick(1);
    checkOutput("t2_lo_addr", 32'(address2), 32'd16382);
    tick(1);
    checkOutput("t2_hi_addr", 32'(address2), 32'd16383);
    tick(2);
    checkOutput("t2_data0", 32'(sample_data), 32'hABCD);
    tick(4);
    checkOutput("t2_rd_ptr", 32'(rd_ptr), 32'd2);
    popOne("t2_s0", 16'hABCD);
    popOne("t2_s1", 16'h01EF);

    // ---- ptr_clr, then backpressure ----
    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 14'd2);
    tick(1);
    ptr_clr = 1'b1;
    tick(1);
    ptr_clr = 1'b0;
    checkOutput("t3_ptr_clr", 32'(rd_ptr), 32'd0);
    for (int i = 0; i < 20; i++) mem[i] = 8'(8'h10 + 7 * i);
    // Hand-computed pairs {mem[2i+1], mem[2i]} of the pattern above.
    exp_s[0] = 16'h1710; exp_s[1] = 16'h251E; exp_s[2] = 16'h332C;
    exp_s[3] = 16'h413A; exp_s[4] = 16'h4F48; exp_s[5] = 16'h5D56;
    exp_s[6] = 16'h6B64; exp_s[7] = 16'h7972; exp_s[8] = 16'h8780;
    exp_s[9] = 16'h958E;
    applyStimulus(1'b1, 1'b0, 14'd20);
    tick(40);
    checkOutput("t3_rd_ptr_park", 32'(rd_ptr), 32'd8);
    checkOutput("t3_valid", 32'(sample_valid), 32'd1);
    checkOutput("t3_cs_park", 32'(chipselect2), 32'd0);
    applyStimulus(1'b1, 1'b1, 14'd20);
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 200) begin
      if (sample_valid) begin
        checkOutput($sformatf("t3_drain%0d", idx), 32'(sample_data), 32'(exp_s[idx]));
        idx++;
      end
      tick(1);
      cyc++;
    end
    checkOutput("t3_drain_count", 32'(idx), 32'd10);
    checkOutput("t3_rd_ptr_end", 32'(rd_ptr), 32'd20);

    // ---- Starvation and underrun priority ----
    $display("[TB] starvation");
    applyStimulus(1'b1, 1'b0, 14'd20);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    checkOutput("t4_clr", 32'(underrun), 32'd0);
    applyStimulus(1'b1, 1'b1, 14'd20);
    tick(1);
    checkOutput("t4_set", 32'(underrun), 32'd1);
    cs_count = 0;
    for (int i = 0; i < 5; i++) begin
      if (chipselect2) cs_count++;
      tick(1);
    end
    checkOutput("t4_no_ram_access", 32'(cs_count), 32'd0);
    underrun_clr = 1'b1;
    tick(1);
    checkOutput("t4_set_wins", 32'(underrun), 32'd1);
    applyStimulus(1'b1, 1'b0, 14'd20);
    tick(1);
    underrun_clr = 1'b0;
    checkOutput("t4_clr2", 32'(underrun), 32'd0);

    // ---- Odd avail ----
    $display("[TB] odd avail");
    mem[20] = 8'h11; mem[21] = 8'h22; mem[22] = 8'h33; mem[23] = 8'h44;
    applyStimulus(1'b1, 1'b0, 14'd23);
    cs_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (chipselect2) cs_count++;
    end
    checkOutput("t5_cs_cycles", 32'(cs_count), 32'd2);
    checkOutput("t5_rd_ptr", 32'(rd_ptr), 32'd22);
    checkOutput("t5_data", 32'(sample_data), 32'h2211);
    applyStimulus(1'b1, 1'b0, 14'd24);
    tick(5);
    checkOutput("t5_rd_ptr2", 32'(rd_ptr), 32'd24);
    popOne("t5_s0", 16'h2211);
    popOne("t5_s1", 16'h4433);

    // ---- Disable mid-fetch, then ptr_clr ----
    $display("[TB] disable during HI");
    mem[24] = 8'h5A; mem[25] = 8'hA5;
    applyStimulus(1'b1, 1'b0, 14'd26);
    tick(2);
    checkOutput("t6_in_hi_cs", 32'(chipselect2), 32'd1);
    checkOutput("t6_in_hi_addr", 32'(address2), 32'd25);
    applyStimulus(1'b0, 1'b0, 14'd26);
    tick(2);
    checkOutput("t6_completed_valid", 32'(sample_valid), 32'd1);
    checkOutput("t6_completed_data", 32'(sample_data), 32'hA55A);
    checkOutput("t6_rd_ptr", 32'(rd_ptr), 32'd26);
    ptr_clr = 1'b1;
    tick(1);
    ptr_clr = 1'b0;
    checkOutput("t6_flushed", 32'(sample_valid), 32'd0);
    checkOutput("t6_ptr_clr", 32'(rd_ptr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
